boot_imem: RTL and testbench
============================

BOOT_IMEM -- requirements
Module: boot_imem

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit instruction words (power of two, 4..4096).
REQ-002 SHALL have parameter NOP_WORD, default 32'hE1A00000, meaning the word returned for unloaded, out-of-range or blocked fetches (MOV R0,R0).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port load_valid, input, 1, meaning a loader word is presented.
REQ-006 SHALL have port load_data, input, 32, meaning the program word being loaded.
REQ-007 SHALL have port load_last, input, 1, meaning the presented word is the final program word.
REQ-008 SHALL have port load_ready, output, 1, meaning the block accepts a load word this cycle.
REQ-009 SHALL have port fetch_en, input, 1, meaning fetch request this cycle.
REQ-010 SHALL have port a, input, 32, meaning the byte address of the fetch.
REQ-011 SHALL have port rd, output, 32, meaning the fetched instruction word.
REQ-012 SHALL have port rd_valid, output, 1, meaning rd holds a fetch result.
REQ-013 SHALL have port running, output, 1, meaning the state is RUN.
REQ-014 SHALL have port fault, output, 1, a sticky flag for misaligned or out-of-range fetches.

Function
REQ-015 SHALL implement a two-state machine: LOAD (entered from reset) and RUN.
REQ-016 In LOAD, load_ready SHALL be 1; a word transfers on a cycle where load_valid and load_ready are both 1, is written at index wptr, and wptr increments.
REQ-017 LOAD->RUN SHALL occur on the cycle after a transfer with load_last=1, or after a transfer at wptr=DEPTH-1 (full); further load words are then refused (load_ready=0).
REQ-018 The block SHALL record loaded count = number of transferred words (1..DEPTH); RUN has no path back to LOAD except reset.
REQ-019 In RUN, a fetch with fetch_en=1 SHALL produce rd and rd_valid=1 on the next cycle (1-cycle registered latency); rd_valid SHALL be 0 in the cycle after fetch_en=0.
REQ-020 Word index SHALL be a[31:2]; a[1:0]!=0 SHALL return NOP_WORD and set fault.
REQ-021 Index >= DEPTH SHALL return NOP_WORD and set fault; index >= loaded count and < DEPTH SHALL return NOP_WORD without fault.
REQ-022 fetch_en in LOAD SHALL be ignored: rd_valid stays 0 and rd holds NOP_WORD.
REQ-023 rd SHALL hold its last value while fetch_en=0.
REQ-024 fault SHALL stay set until reset.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force: state LOAD, wptr 0, loaded count 0, rd NOP_WORD, rd_valid 0, fault 0, running 0, load_ready 0 while asserted, 1 from the first edge after release.
REQ-026 Memory array contents SHALL NOT be reset; reset mid-load discards progress, and earlier words are unreachable until reloaded (count=0).

Configuration
REQ-027 Macro BOOT_IMEM_CHECKSUM_EN SHALL, when defined, add output checksum[31:0]: XOR of all transferred load words, reset to 0, frozen after entering RUN.
REQ-028 Without BOOT_IMEM_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package arm_mem_pkg SHALL hold the state enum (LOAD, RUN), the default NOP encoding constant and the word-width constant.
REQ-030 Storage SHALL be a sub-module imem_ram (single-port, synchronous write, synchronous read, DEPTH x 32).

Verification
REQ-031 Load 4 words (E2800008, E0411001, E2400008, EA000000, last on the 4th) -> running=1 next cycle; fetch a=0x4 -> rd=E0411001, rd_valid=1 one cycle later.
REQ-032 After REQ-031, fetch a=0x10 (index 4 < DEPTH, not loaded) -> rd=E1A00000, fault=0; fetch a=0x102 -> rd=E1A00000, fault=1, and fault stays 1.
REQ-033 DEPTH=64, load 64 words without load_last -> RUN after the 64th; 65th load_valid sees load_ready=0; fetch a=0x100 -> NOP_WORD, fault=1.
REQ-034 Toggle load_valid with gaps and assert fetch_en during LOAD -> only handshaked words are stored, rd_valid stays 0.
REQ-035 Assert reset_n=0 after 2 of 4 words loaded -> all outputs at reset values asynchronously; reload 3 words -> fetch index 3 returns NOP_WORD.
REQ-036 With BOOT_IMEM_CHECKSUM_EN, load words 0000000F, 000000F0 -> checksum=000000FF, unchanged by later fetches.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM boot instruction memory.
//   WORD_W      : instruction word width in bits
//   NOP_DEFAULT : MOV R0,R0, returned for any fetch that cannot hit the array
//   boot_state_t: LOAD (program is being streamed in) / RUN (fetches served)
package arm_mem_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_DEFAULT = 32'hE1A00000;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } boot_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM, DEPTH x WORD_W.
// Synchronous write and synchronous read on the same address port.
//   clk   : clock
//   we    : write wdata to mem[addr] on the rising edge
//   re    : capture mem[addr] into rdata on the rising edge (rdata holds otherwise)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module imem_ram
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: neither the array nor its read register is reset; a reset port here
  // would stop the array mapping onto a RAM macro, and the top masks stale data.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/boot_imem.sv
// Boot instruction memory: a loader streams a program in (LOAD state), after
// which the core fetches instruction words by byte address (RUN state).
// Optional feature macro: BOOT_IMEM_CHECKSUM_EN adds a checksum output that
// XORs every accepted load word and freezes once RUN is entered.
//   clk, reset_n           : clock, asynchronous active-low reset
//   load_valid/data/last   : loader word stream; load_ready accepts it
//   fetch_en, a            : fetch request with byte address
//   rd, rd_valid           : fetched word, valid the cycle after the request
//   running                : state is RUN
//   fault                  : sticky misaligned / out-of-range fetch flag
//   checksum (optional)    : XOR of all loaded words
module boot_imem
  import arm_mem_pkg::*;
#(
  parameter int unsigned       DEPTH    = 64,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              fetch_en,
  input  logic [31:0]       a,
  output logic [WORD_W-1:0] rd,
  output logic              rd_valid,
  output logic              running,
  output logic              fault
`ifdef BOOT_IMEM_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  boot_state_t       state;
  logic [AW-1:0]     wptr;
  logic [AW:0]       count;     // words loaded, 0..DEPTH
  logic              ready_q;
  logic              valid_q;
  logic              sel_ram_q; // last fetch hit loaded storage
  logic              fault_q;

  logic              xfer;
  logic              fetch;
  logic              misaligned;
  logic              out_of_range;
  logic              unloaded;
  logic              hit;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_rdata;

  // ready_q is only ever 1 in LOAD, so a transfer implies LOAD.
  assign xfer  = load_valid & ready_q;
  assign fetch = (state == RUN) & fetch_en;

  // NOTE: every signal is assigned on every path through this block, so no
  // latch can be inferred.
  always_comb begin
    misaligned   = |a[1:0];
    out_of_range = |a[31:AW+2];
    unloaded     = ({1'b0, a[AW+1:2]} >= count);
    hit          = !(misaligned | out_of_range | unloaded);
    // One RAM port: the write pointer owns it while loading, the fetch index after.
    ram_addr     = (state == LOAD) ? wptr : a[AW+1:2];
  end

  imem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .re    (fetch),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOAD;
      wptr      <= '0;
      count     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      sel_ram_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          ready_q <= 1'b1;
          if (xfer) begin
            wptr  <= wptr + 1'b1;
            count <= count + 1'b1;
            if (load_last || wptr == LAST_IDX) begin
              state   <= RUN;
              ready_q <= 1'b0;
            end
          end
        end
        RUN: begin
          valid_q <= fetch_en;
          if (fetch_en) begin
            sel_ram_q <= hit;
            if (misaligned || out_of_range) fault_q <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef BOOT_IMEM_CHECKSUM_EN
  // Transfers only happen in LOAD, so the value freezes on entering RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  checksum <= '0;
    else if (xfer) checksum <= checksum ^ load_data;
  end
`endif

  // rd holds between fetches because both the RAM read register and the
  // select flag only update on a fetch.
  assign rd         = sel_ram_q ? ram_rdata : NOP_WORD;
  assign rd_valid   = valid_q;
  assign running    = (state == RUN);
  assign fault      = fault_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_boot_imem.sv
// Directed bench for boot_imem (DEPTH=64, default NOP word).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. they reflect the edge just taken.
module tb_boot_imem;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk;
  logic        reset_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        fetch_en;
  logic [31:0] a;
  logic [31:0] rd;
  logic        rd_valid;
  logic        running;
  logic        fault;
`ifdef BOOT_IMEM_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int passed;
  int total;

  boot_imem #(
    .DEPTH    (64),
    .NOP_WORD (32'hE1A00000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .fetch_en   (fetch_en),
    .a          (a),
    .rd         (rd),
    .rd_valid   (rd_valid),
    .running    (running),
    .fault      (fault)
`ifdef BOOT_IMEM_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    fetch_en   = 1'b0;
    a          = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic fetch(input logic [31:0] addr);
    fetch_en = 1'b1;
    a        = addr;
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    fetch_en   = 1'b0;
    a          = '0;
    #2;
    total++; if (load_ready !== 1'b0) $display("FAIL reset_load_ready: got %b exp 0", load_ready); else passed++;
    total++; if (running !== 1'b0) $display("FAIL reset_running: got %b exp 0", running); else passed++;
    total++; if (rd !== NOP) $display("FAIL reset_rd: got %h exp %h", rd, NOP); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b exp 0", fault); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    total++; if (load_ready !== 1'b1) $display("FAIL release_load_ready: got %b exp 1", load_ready); else passed++;
  endtask

  // Four-word program, then fetch word 1.
  task automatic test_load_and_fetch();
    logic [31:0] prog [4];
    prog[0] = 32'hE2800008; prog[1] = 32'hE0411001;
    prog[2] = 32'hE2400008; prog[3] = 32'hEA000000;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == 3);
      tick();
      if (i == 2) begin
        total++; if (running !== 1'b0) $display("FAIL load_not_yet_running: got %b exp 0", running); else passed++;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    total++; if (running !== 1'b1) $display("FAIL load_running: got %b exp 1", running); else passed++;
    total++; if (load_ready !== 1'b0) $display("FAIL load_ready_in_run: got %b exp 0", load_ready); else passed++;
    fetch(32'h4);
    total++; if (rd !== 32'hE0411001) $display("FAIL fetch_w1_rd: got %h exp E0411001", rd); else passed++;
    total++; if (rd_valid !== 1'b1) $display("FAIL fetch_w1_valid: got %b exp 1", rd_valid); else passed++;
    tick();
    total++; if (rd_valid !== 1'b0) $display("FAIL idle_valid: got %b exp 0", rd_valid); else passed++;
    total++; if (rd !== 32'hE0411001) $display("FAIL idle_rd_hold: got %h exp E0411001", rd); else passed++;
  endtask

  task automatic test_unloaded_and_fault();
    fetch(32'h10);
    total++; if (rd !== NOP) $display("FAIL unloaded_rd: got %h exp %h", rd, NOP); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL unloaded_fault: got %b exp 0", fault); else passed++;
    fetch(32'h102);
    total++; if (rd !== NOP) $display("FAIL oor_rd: got %h exp %h", rd, NOP); else passed++;
    total++; if (fault !== 1'b1) $display("FAIL oor_fault: got %b exp 1", fault); else passed++;
    fetch(32'h0);
    total++; if (rd !== 32'hE2800008) $display("FAIL after_fault_rd: got %h exp E2800008", rd); else passed++;
    total++; if (fault !== 1'b1) $display("FAIL fault_sticky: got %b exp 1", fault); else passed++;
    fetch(32'hC);
    total++; if (rd !== 32'hEA000000) $display("FAIL last_word_rd: got %h exp EA000000", rd); else passed++;
    fetch(32'h5);
    total++; if (rd !== NOP) $display("FAIL misaligned_rd: got %h exp %h", rd, NOP); else passed++;
  endtask

  // Misaligned-only fault on a fresh load.
  task automatic test_misaligned();
    do_reset();
    load_valid = 1'b1; load_data = 32'hCAFE0000; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    fetch(32'h1);
    total++; if (rd !== NOP) $display("FAIL misal_only_rd: got %h exp %h", rd, NOP); else passed++;
    total++; if (fault !== 1'b1) $display("FAIL misal_only_fault: got %b exp 1", fault); else passed++;
  endtask

  task automatic test_full_load();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h10000000 + i;
      load_last  = 1'b0;
      tick();
      if (i == 62) begin
        total++; if (running !== 1'b0) $display("FAIL full_63_running: got %b exp 0", running); else passed++;
      end
    end
    total++; if (running !== 1'b1) $display("FAIL full_running: got %b exp 1", running); else passed++;
    load_data = 32'hBADBAD00;
    total++; if (load_ready !== 1'b0) $display("FAIL full_65th_ready: got %b exp 0", load_ready); else passed++;
    tick();
    load_valid = 1'b0;
    fetch(32'h0);
    total++; if (rd !== 32'h10000000) $display("FAIL full_w0: got %h exp 10000000", rd); else passed++;
    fetch(32'hFC);
    total++; if (rd !== 32'h1000003F) $display("FAIL full_w63: got %h exp 1000003F", rd); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL full_w63_fault: got %b exp 0", fault); else passed++;
    fetch(32'h100);
    total++; if (rd !== NOP) $display("FAIL full_oor_rd: got %h exp %h", rd, NOP); else passed++;
    total++; if (fault !== 1'b1) $display("FAIL full_oor_fault: got %b exp 1", fault); else passed++;
  endtask

  // Reset asserted between edges while in RUN with fault and rd_valid set.
  task automatic test_async_reset();
    fetch_en = 1'b1;
    a        = 32'h8;
    tick();
    total++; if (rd !== 32'h10000002) $display("FAIL pre_async_rd: got %h exp 10000002", rd); else passed++;
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (rd !== NOP) $display("FAIL async_rd: got %h exp %h", rd, NOP); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL async_rd_valid: got %b exp 0", rd_valid); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL async_fault: got %b exp 0", fault); else passed++;
    total++; if (running !== 1'b0) $display("FAIL async_running: got %b exp 0", running); else passed++;
    total++; if (load_ready !== 1'b0) $display("FAIL async_load_ready: got %b exp 0", load_ready); else passed++;
    fetch_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    total++; if (load_ready !== 1'b1) $display("FAIL async_release_ready: got %b exp 1", load_ready); else passed++;
  endtask

  task automatic test_gapped_load();
    logic [31:0] data [5];
    logic        vld  [5];
    data[0] = 32'h11111111; vld[0] = 1'b1;
    data[1] = 32'hBAD00001; vld[1] = 1'b0;
    data[2] = 32'h22222222; vld[2] = 1'b1;
    data[3] = 32'hBAD00002; vld[3] = 1'b0;
    data[4] = 32'h33333333; vld[4] = 1'b1;
    do_reset();
    fetch_en = 1'b1;
    a        = 32'h0;
    for (int i = 0; i < 5; i++) begin
      load_valid = vld[i];
      load_data  = data[i];
      load_last  = (i == 4);
      if (i == 4) fetch_en = 1'b0;
      tick();
      if (i < 4) begin
        total++; if (rd_valid !== 1'b0) $display("FAIL gap_rd_valid_%0d: got %b exp 0", i, rd_valid); else passed++;
        total++; if (rd !== NOP) $display("FAIL gap_rd_%0d: got %h exp %h", i, rd, NOP); else passed++;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    total++; if (running !== 1'b1) $display("FAIL gap_running: got %b exp 1", running); else passed++;
    fetch(32'h0);
    total++; if (rd !== 32'h11111111) $display("FAIL gap_w0: got %h exp 11111111", rd); else passed++;
    fetch(32'h4);
    total++; if (rd !== 32'h22222222) $display("FAIL gap_w1: got %h exp 22222222", rd); else passed++;
    fetch(32'h8);
    total++; if (rd !== 32'h33333333) $display("FAIL gap_w2: got %h exp 33333333", rd); else passed++;
    fetch(32'hC);
    total++; if (rd !== NOP) $display("FAIL gap_w3: got %h exp %h", rd, NOP); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL gap_fault: got %b exp 0", fault); else passed++;
  endtask

  // Index 3 still holds 10000003 from the full load; the reload count of 3 must hide it.
  task automatic test_reset_midload();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hAAAA0000 + i;
      tick();
    end
    load_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (load_ready !== 1'b0) $display("FAIL midload_ready: got %b exp 0", load_ready); else passed++;
    total++; if (running !== 1'b0) $display("FAIL midload_running: got %b exp 0", running); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h55550000 + i;
      load_last  = (i == 2);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch(32'h8);
    total++; if (rd !== 32'h55550002) $display("FAIL reload_w2: got %h exp 55550002", rd); else passed++;
    fetch(32'hC);
    total++; if (rd !== NOP) $display("FAIL reload_w3: got %h exp %h", rd, NOP); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL reload_fault: got %b exp 0", fault); else passed++;
  endtask

`ifdef BOOT_IMEM_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    total++; if (checksum !== 32'h0) $display("FAIL csum_reset: got %h exp 00000000", checksum); else passed++;
    load_valid = 1'b1; load_data = 32'h0000000F; load_last = 1'b0;
    tick();
    load_data = 32'h000000F0; load_last = 1'b1;
    tick();
    load_data = 32'h12345678; load_last = 1'b0;
    tick();
    load_valid = 1'b0;
    total++; if (checksum !== 32'h000000FF) $display("FAIL csum_value: got %h exp 000000FF", checksum); else passed++;
    fetch(32'h0);
    fetch(32'h4);
    total++; if (checksum !== 32'h000000FF) $display("FAIL csum_frozen: got %h exp 000000FF", checksum); else passed++;
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_load_and_fetch();
    test_unloaded_and_fault();
    test_misaligned();
    test_full_load();
    test_async_reset();
    test_gapped_load();
    test_reset_midload();
`ifdef BOOT_IMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
